// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default sizes, address type and FSM state encoding.
package mem_arbiter_pkg;

    localparam int unsigned DEF_PROC_COUNT = 4;
    localparam int unsigned DEF_BUS_W      = 8;
    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned WR_SIZE_W      = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after (last + 1), wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_onehot_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_any_c
);

    logic [IDX_W-1:0] w_k;

    // Scan N positions starting just after the last grant; the first hit wins.
    always_comb begin
        o_onehot_c = '0;
        o_idx_c    = '0;
        o_any_c    = 1'b0;
        w_k        = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            w_k = IDX_W'((32'(i_last) + off) % N);
            if (!o_any_c && i_req[w_k]) begin
                o_any_c         = 1'b1;
                o_onehot_c[w_k] = 1'b1;
                o_idx_c         = w_k;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one processor at a time access to a single memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned PROC_COUNT = DEF_PROC_COUNT,
    parameter int unsigned BUS_W      = DEF_BUS_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [PROC_COUNT-1:0] i_req_rd,
    input  logic [PROC_COUNT-1:0] i_req_wr,
    input  addr_t                 i_addr    [PROC_COUNT],
    input  logic [BUS_W-1:0]      i_data    [PROC_COUNT],
    input  logic [WR_SIZE_W-1:0]  i_wr_size [PROC_COUNT],
    output logic [PROC_COUNT-1:0] o_grant_rd,
    output logic [PROC_COUNT-1:0] o_grant_wr,
    output logic [PROC_COUNT-1:0] o_valid,
    output logic [BUS_W-1:0]      o_rd_data,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output addr_t                 o_mem_addr,
    output logic [BUS_W-1:0]      o_mem_data,
    output logic [WR_SIZE_W-1:0]  o_mem_wr_size,
    input  logic                  i_mem_ack,
    input  logic [BUS_W-1:0]      i_mem_data
);

    localparam int unsigned IDX_W = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

    arb_state_e              r_state;
    logic [PROC_COUNT-1:0]   r_grant_rd;
    logic [PROC_COUNT-1:0]   r_grant_wr;
    logic [PROC_COUNT-1:0]   r_valid;
    logic [BUS_W-1:0]        r_rd_data;
    logic                    r_mem_rd;
    logic                    r_mem_wr;
    logic [IDX_W-1:0]        r_gidx;
    logic [IDX_W-1:0]        r_last;

    arb_state_e              w_state_nxt;
    logic [PROC_COUNT-1:0]   w_grant_rd_nxt;
    logic [PROC_COUNT-1:0]   w_grant_wr_nxt;
    logic [PROC_COUNT-1:0]   w_valid_nxt;
    logic [BUS_W-1:0]        w_rd_data_nxt;
    logic                    w_mem_rd_nxt;
    logic                    w_mem_wr_nxt;
    logic [IDX_W-1:0]        w_gidx_nxt;
    logic [IDX_W-1:0]        w_last_nxt;

    logic [PROC_COUNT-1:0]   w_req_any;
    logic [PROC_COUNT-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_pick_any;

    assign w_req_any = i_req_rd | i_req_wr;

    rr_pick #(
        .N     (PROC_COUNT),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req      (w_req_any),
        .i_last     (r_last),
        .o_onehot_c (w_pick_onehot),
        .o_idx_c    (w_pick_idx),
        .o_any_c    (w_pick_any)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_grant_rd <= '0;
            r_grant_wr <= '0;
            r_valid    <= '0;
            r_rd_data  <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_gidx     <= '0;
            r_last     <= IDX_W'(PROC_COUNT - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_grant_rd <= w_grant_rd_nxt;
            r_grant_wr <= w_grant_wr_nxt;
            r_valid    <= w_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_gidx     <= w_gidx_nxt;
            r_last     <= w_last_nxt;
        end
    end

    // Next-state: a write request on the picked processor beats its read request.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_rd_nxt = r_grant_rd;
        w_grant_wr_nxt = r_grant_wr;
        w_valid_nxt    = '0;
        w_rd_data_nxt  = r_rd_data;
        w_mem_rd_nxt   = r_mem_rd;
        w_mem_wr_nxt   = r_mem_wr;
        w_gidx_nxt     = r_gidx;
        w_last_nxt     = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_BUSY;
                    w_gidx_nxt  = w_pick_idx;
                    if (|(i_req_wr & w_pick_onehot)) begin
                        w_grant_wr_nxt = w_pick_onehot;
                        w_mem_wr_nxt   = 1'b1;
                    end else begin
                        w_grant_rd_nxt = w_pick_onehot;
                        w_mem_rd_nxt   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (i_mem_ack) begin
                    w_state_nxt    = ST_IDLE;
                    w_grant_rd_nxt = '0;
                    w_grant_wr_nxt = '0;
                    w_mem_rd_nxt   = 1'b0;
                    w_mem_wr_nxt   = 1'b0;
                    w_last_nxt     = r_gidx;
                    if (r_mem_rd) begin
                        w_valid_nxt   = r_grant_rd;
                        w_rd_data_nxt = i_mem_data;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_grant_rd    = r_grant_rd;
    assign o_grant_wr    = r_grant_wr;
    assign o_valid       = r_valid;
    assign o_rd_data     = r_rd_data;
    assign o_mem_rd      = r_mem_rd;
    assign o_mem_wr      = r_mem_wr;

    // Memory-side fields follow the granted processor directly.
    assign o_mem_addr    = i_addr[r_gidx];
    assign o_mem_data    = i_data[r_gidx];
    assign o_mem_wr_size = i_wr_size[r_gidx];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, fairness, write priority, withdrawal and reset abort.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned PC = 4;
    localparam int unsigned BW = 8;

    logic          clk;
    logic          rstn;
    logic [PC-1:0] req_rd;
    logic [PC-1:0] req_wr;
    addr_t         addr    [PC];
    logic [BW-1:0] data    [PC];
    logic [2:0]    wr_size [PC];
    logic [PC-1:0] grant_rd;
    logic [PC-1:0] grant_wr;
    logic [PC-1:0] valid;
    logic [BW-1:0] rd_data;
    logic          mem_rd;
    logic          mem_wr;
    addr_t         mem_addr;
    logic [BW-1:0] mem_data;
    logic [2:0]    mem_wr_size;
    logic          mem_ack;
    logic [BW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .PROC_COUNT (PC),
        .BUS_W      (BW)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_req_rd      (req_rd),
        .i_req_wr      (req_wr),
        .i_addr        (addr),
        .i_data        (data),
        .i_wr_size     (wr_size),
        .o_grant_rd    (grant_rd),
        .o_grant_wr    (grant_wr),
        .o_valid       (valid),
        .o_rd_data     (rd_data),
        .o_mem_rd      (mem_rd),
        .o_mem_wr      (mem_wr),
        .o_mem_addr    (mem_addr),
        .o_mem_data    (mem_data),
        .o_mem_wr_size (mem_wr_size),
        .i_mem_ack     (mem_ack),
        .i_mem_data    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grd"}, 32'(grant_rd), 32'h0);
        chk({tag, "_gwr"}, 32'(grant_wr), 32'h0);
        chk({tag, "_mrd"}, 32'(mem_rd), 32'h0);
        chk({tag, "_mwr"}, 32'(mem_wr), 32'h0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        logic [PC-1:0] one;
        int            order [5];
        rstn      = 1'b0;
        req_rd    = '0;
        req_wr    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < int'(PC); i++) begin
            addr[i]    = addr_t'(16'h1000 + 16'(i) * 16'h0111);
            data[i]    = BW'(8'h10 + 8'(i));
            wr_size[i] = 3'(i);
        end
        addr[2] = 16'h1234;
        data[1] = 8'h5A;
        wr_size[1] = 3'd2;

        // Reset values
        #12;
        chk_idle("rst");
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_rdata", 32'(rd_data), 32'h0);
        tick();
        rstn = 1'b1;
        tick();

        // Single read to proc 2, ack at cycle 3
        req_rd = 4'b0100;
        tick();
        chk("rd1_grant_c1", 32'(grant_rd), 32'h4);
        chk("rd1_gwr_c1", 32'(grant_wr), 32'h0);
        chk("rd1_memrd_c1", 32'(mem_rd), 32'h1);
        chk("rd1_addr_c1", 32'(mem_addr), 32'h1234);
        req_rd = '0;
        tick();
        chk("rd1_grant_c2", 32'(grant_rd), 32'h4);
        tick();
        chk("rd1_grant_c3", 32'(grant_rd), 32'h4);
        chk("rd1_valid_c3", 32'(valid), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 8'hA5;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        chk("rd1_valid_c4", 32'(valid), 32'h4);
        chk("rd1_rdata_c4", 32'(rd_data), 32'hA5);
        chk_idle("rd1_c4");
        tick();
        chk("rd1_valid_c5", 32'(valid), 32'h0);
        chk("rd1_rdata_c5", 32'(rd_data), 32'hA5);

        // Stray ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        chk_idle("stray");
        chk("stray_valid", 32'(valid), 32'h0);
        chk("stray_rdata", 32'(rd_data), 32'hA5);

        // Fairness from reset: 0,1,2,3,0
        do_reset();
        order = '{0, 1, 2, 3, 0};
        req_rd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            one = PC'(1) << order[i];
            tick();
            chk($sformatf("fair_grant%0d", i), 32'(grant_rd), 32'(one));
            mem_ack   = 1'b1;
            mem_rdata = BW'(8'hC0 + 8'(i));
            tick();
            mem_ack = 1'b0;
            chk($sformatf("fair_valid%0d", i), 32'(valid), 32'(one));
            chk($sformatf("fair_rdata%0d", i), 32'(rd_data), 32'hC0 + 32'(i));
        end
        req_rd = '0;
        tick();
        chk("fair_end_valid", 32'(valid), 32'h0);

        // Read and write from proc 1: write first, then read, one valid pulse
        req_rd = 4'b0010;
        req_wr = 4'b0010;
        tick();
        chk("rw_gwr", 32'(grant_wr), 32'h2);
        chk("rw_grd", 32'(grant_rd), 32'h0);
        chk("rw_memwr", 32'(mem_wr), 32'h1);
        chk("rw_memrd", 32'(mem_rd), 32'h0);
        chk("rw_wdata", 32'(mem_data), 32'h5A);
        chk("rw_wsize", 32'(mem_wr_size), 32'h2);
        req_wr    = '0;
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        chk("rw_wack_valid", 32'(valid), 32'h0);
        chk("rw_wack_rdata", 32'(rd_data), 32'hC4);
        chk_idle("rw_wack");
        tick();
        chk("rw_rd_grant", 32'(grant_rd), 32'h2);
        chk("rw_rd_memrd", 32'(mem_rd), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        req_rd  = '0;
        chk("rw_rd_valid", 32'(valid), 32'h2);
        chk("rw_rd_rdata", 32'(rd_data), 32'h77);
        tick();
        chk("rw_rd_valid_off", 32'(valid), 32'h0);

        // Reset mid-BUSY on a read to proc 0
        req_rd = 4'b0001;
        tick();
        chk("rb_grant_c1", 32'(grant_rd), 32'h1);
        tick();
        tick();
        req_rd = '0;
        rstn   = 1'b0;
        #1;
        chk_idle("rb_async");
        chk("rb_async_valid", 32'(valid), 32'h0);
        chk("rb_async_rdata", 32'(rd_data), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        rstn    = 1'b1;
        tick();
        chk("rb_post_valid", 32'(valid), 32'h0);
        chk_idle("rb_post");
        req_rd = 4'b1001;
        tick();
        chk("rb_next_grant", 32'(grant_rd), 32'h1);
        req_rd    = '0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
        chk("rb_next_valid", 32'(valid), 32'h1);
        tick();

        // Write from proc 3 withdrawn at cycle 2, ack at cycle 4
        req_wr = 4'b1000;
        tick();
        chk("wd_memwr_c1", 32'(mem_wr), 32'h1);
        chk("wd_gwr_c1", 32'(grant_wr), 32'h8);
        tick();
        req_wr = '0;
        chk("wd_memwr_c2", 32'(mem_wr), 32'h1);
        tick();
        chk("wd_memwr_c3", 32'(mem_wr), 32'h1);
        chk("wd_gwr_c3", 32'(grant_wr), 32'h8);
        tick();
        chk("wd_memwr_c4", 32'(mem_wr), 32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_idle("wd_c5");
        chk("wd_valid_c5", 32'(valid), 32'h0);
        tick();
        chk_idle("wd_c6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter PROC_COUNT, default `PROC_COUNT, number of requesting processors.
REQ-002 Parameter BUS_W, default `BUS_W, data bus width.
REQ-003 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_req_rd  in  PROC_COUNT  per-processor read request (level).
REQ-006 i_req_wr  in  PROC_COUNT  per-processor write request (level).
REQ-007 i_addr  in  addr_t [PROC_COUNT]  per-processor address.
REQ-008 i_data  in  BUS_W [PROC_COUNT]  per-processor write data.
REQ-009 i_wr_size  in  3 [PROC_COUNT]  per-processor write size.
REQ-010 o_grant_rd  out  PROC_COUNT  one-hot-or-zero read grant.
REQ-011 o_grant_wr  out  PROC_COUNT  one-hot-or-zero write grant.
REQ-012 o_valid  out  PROC_COUNT  one-cycle pulse: read data valid for that processor.
REQ-013 o_rd_data  out  BUS_W  registered read data, broadcast to all processors.
REQ-014 o_mem_rd / o_mem_wr  out  1 each  memory read/write strobe, held until ack.
REQ-015 o_mem_addr  out  addr_t; o_mem_data  out  BUS_W; o_mem_wr_size  out  3: granted processor's fields.
REQ-016 i_mem_ack  in  1  memory completion, one cycle; i_mem_data  in  BUS_W  read data, valid with ack.

Function
REQ-017 FSM states IDLE and BUSY; reset state IDLE.
REQ-018 IDLE: if any request bit is set, select the first requester at or after (last_grant+1) modulo PROC_COUNT; register grant; go to BUSY.
REQ-019 IDLE with no request: stay IDLE; all grants and strobes 0.
REQ-020 When a processor asserts both rd and wr, write wins; read stays pending.
REQ-021 BUSY: exactly one grant bit set; o_mem_rd/o_mem_wr match grant type; mem fields muxed combinationally from the granted index.
REQ-022 BUSY, i_mem_ack=1: next cycle grant, strobes cleared; state IDLE; last_grant updated to granted index.
REQ-023 Read ack: next cycle o_valid[g]=1 for one cycle, o_rd_data=i_mem_data captured at ack; o_rd_data holds until the next read ack.
REQ-024 Write ack: no o_valid pulse.
REQ-025 Latency: request at cycle 0 -> grant/strobe at cycle 1; ack at cycle k -> valid and grant drop at k+1; next grant earliest k+2.
REQ-026 Request withdrawn while granted: ignored; transaction completes normally.
REQ-027 i_mem_ack while IDLE: ignored.
REQ-028 Index math uses $clog2(PROC_COUNT) bits; wrap from PROC_COUNT-1 to 0; PROC_COUNT=1 always grants index 0.

Reset
REQ-029 Async reset clears: state=IDLE, o_grant_rd=o_grant_wr=o_valid=0, o_mem_rd=o_mem_wr=0, o_rd_data=0, last_grant=PROC_COUNT-1 (so index 0 is first served).
REQ-030 Reset during BUSY aborts the transaction; no o_valid pulse after release.

Structure
REQ-031 addr_t, BUS_W, PROC_COUNT come from the shared defines package; arbiter state enum goes in that package.
REQ-032 One sub-module, rr_pick: combinational round-robin selector (request vector, last index -> one-hot, index, any).

Verification
REQ-033 Single read: req_rd[2]=1 at cycle 0, ack at cycle 3 with mem_data=0xA5 -> grant_rd[2] cycles 1-3, valid[2] at cycle 4, o_rd_data=0xA5.
REQ-034 Fairness: req_rd=4'b1111 held, ack every 2nd cycle -> grants in order 0,1,2,3,0.
REQ-035 Rd+wr same processor: req_rd[1]=req_wr[1]=1 -> write granted first, read granted next; one o_valid[1] pulse only.
REQ-036 Withdrawal: req_wr[3] dropped cycle 2, ack cycle 4 -> o_mem_wr held 1-4, grant cleared cycle 5.
REQ-037 Reset mid-BUSY: i_rstn low cycle 3 during read to proc 0 -> all outputs 0 immediately; no valid after release; next grant goes to proc 0.
REQ-038 Stray ack in IDLE -> no outputs change.
